// File: rtl/bus_frame_rx_if.sv
// bus_frame_rx_if: byte input stream, payload output handshake and status lines of bus_frame_rx.
interface bus_frame_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ack;
    logic       nack;
    logic [7:0] err_count;
    logic       busy;
    modport slave (input in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid, ack, nack, err_count, busy);
    modport master (output in_data, in_valid, out_ready,
                    input in_ready, out_data, out_valid, ack, nack, err_count, busy);
endinterface

// File: rtl/bus_frame_rx.sv
// bus_frame_rx: receives a data byte then an XOR checksum byte, acks/nacks the frame
// and holds a good payload until the consumer takes it.
module bus_frame_rx #(
    parameter logic [7:0] KEY     = 8'b00110111,
    parameter int         TIMEOUT = 16
) (
    input logic         clk,
    input logic         reset,
    bus_frame_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_CHK, CHECK, HOLD} state_t;
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    state_t     state, state_n;
    logic [7:0] timer, timer_n, data, data_n, chk, chk_n;
    logic [7:0] out_data, out_data_n, err_count, err_n;
    logic       out_valid, out_valid_n, ack, ack_n, nack, nack_n;
    logic       accept, fail;
    assign bus.in_ready  = state == IDLE || state == WAIT_CHK;
    assign bus.busy      = state != IDLE;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.ack       = ack;
    assign bus.nack      = nack;
    assign bus.err_count = err_count;
    assign accept        = bus.in_valid && bus.in_ready;
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        data_n      = data;
        chk_n       = chk;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        ack_n       = 1'b0;
        fail        = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                data_n  = bus.in_data;
                timer_n = 8'd0;
                state_n = WAIT_CHK;
            end
            // an accept on the last allowed cycle beats the timeout
            WAIT_CHK: if (accept) begin
                chk_n   = bus.in_data;
                state_n = CHECK;
            end else if (timer == TLAST) begin
                fail    = 1'b1;
                state_n = IDLE;
            end else begin
                timer_n = timer + 8'd1;
            end
            CHECK: if ((data ^ KEY) == chk) begin
                out_data_n  = data;
                out_valid_n = 1'b1;
                ack_n       = 1'b1;
                state_n     = HOLD;
            end else begin
                fail    = 1'b1;
                state_n = IDLE;
            end
            HOLD: if (bus.out_ready) begin
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
        nack_n = fail;
        err_n  = (fail && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= 8'd0;
            data      <= 8'd0;
            chk       <= 8'd0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            ack       <= 1'b0;
            nack      <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            data      <= data_n;
            chk       <= chk_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            ack       <= ack_n;
            nack      <= nack_n;
            err_count <= err_n;
        end
    end
endmodule

// File: tb/tb_bus_frame_rx.sv
// tb_bus_frame_rx: frame table, hand-written corner sequences and random frames checked
// against a transaction-level model of the receiver.
module tb_bus_frame_rx;
    localparam logic [7:0] KEY     = 8'h37;
    localparam int         TIMEOUT = 16;
    logic clk = 1'b0;
    logic reset;
    bus_frame_rx_if bus ();
    bus_frame_rx #(.KEY(KEY), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        int         gap;
        int         hold;
        logic       ack;
        logic [7:0] err;
    } vec_t;
    vec_t tv[10];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_err = 8'd0;
    logic [7:0] exp_od  = 8'd0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_outputs(input string name);
        cmp({name, "_ready"}, bus.in_ready, 1'b1);
        cmp({name, "_busy"}, bus.busy, 1'b0);
        cmp({name, "_ovalid"}, bus.out_valid, 1'b0);
        cmp({name, "_ack"}, bus.ack, 1'b0);
        cmp({name, "_nack"}, bus.nack, 1'b0);
        cmp({name, "_err"}, bus.err_count, exp_err);
        cmp({name, "_odata"}, bus.out_data, exp_od);
    endtask

    // Drives one frame from IDLE; gap = idle cycles between data and checksum,
    // gap >= TIMEOUT means no checksum is offered and the frame must time out.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] c, input int gap,
                             input int hold, input logic exp_ack);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick;
        cmp("data_busy", bus.busy, 1'b1);
        bus.in_valid = 1'b0;
        if (gap >= TIMEOUT) begin
            repeat (TIMEOUT - 1) begin
                tick;
                cmp("wait_nack", bus.nack, 1'b0);
                cmp("wait_ready", bus.in_ready, 1'b1);
            end
            tick;
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            cmp("to_nack", bus.nack, 1'b1);
            cmp("to_ack", bus.ack, 1'b0);
            cmp("to_busy", bus.busy, 1'b0);
            cmp("to_ready", bus.in_ready, 1'b1);
            cmp("to_err", bus.err_count, exp_err);
            tick;
            cmp("to_nack_end", bus.nack, 1'b0);
            return;
        end
        repeat (gap) begin
            tick;
            cmp("gap_nack", bus.nack, 1'b0);
        end
        bus.in_data  = c;
        bus.in_valid = 1'b1;
        tick;
        bus.in_data = ~d;
        cmp("chk_ready", bus.in_ready, 1'b0);
        cmp("chk_busy", bus.busy, 1'b1);
        cmp("chk_ack", bus.ack, 1'b0);
        tick;
        if (exp_ack) begin
            exp_od = d;
            cmp("ok_ack", bus.ack, 1'b1);
            cmp("ok_nack", bus.nack, 1'b0);
            cmp("ok_ovalid", bus.out_valid, 1'b1);
            cmp("ok_odata", bus.out_data, d);
            cmp("ok_err", bus.err_count, exp_err);
            for (int i = 0; i < hold; i++) begin
                tick;
                cmp("hold_ovalid", bus.out_valid, 1'b1);
                cmp("hold_odata", bus.out_data, d);
                cmp("hold_ack", bus.ack, 1'b0);
                cmp("hold_ready", bus.in_ready, 1'b0);
            end
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b0;
            tick;
            bus.out_ready = 1'b0;
            cmp("rel_ovalid", bus.out_valid, 1'b0);
            cmp("rel_busy", bus.busy, 1'b0);
            cmp("rel_ack", bus.ack, 1'b0);
        end else begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            bus.in_valid = 1'b0;
            cmp("bad_nack", bus.nack, 1'b1);
            cmp("bad_ack", bus.ack, 1'b0);
            cmp("bad_ovalid", bus.out_valid, 1'b0);
            cmp("bad_odata", bus.out_data, exp_od);
            cmp("bad_err", bus.err_count, exp_err);
            cmp("bad_busy", bus.busy, 1'b0);
            tick;
            cmp("bad_nack_end", bus.nack, 1'b0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tv[0] = '{8'hAA, 8'h9D, 0, 0, 1'b1, 8'd0};
        tv[1] = '{8'hAD, 8'h9B, 0, 0, 1'b0, 8'd1};
        tv[2] = '{8'hAF, 8'hAF, 0, 0, 1'b0, 8'd2};
        tv[3] = '{8'h55, 8'h00, 16, 0, 1'b0, 8'd3};
        tv[4] = '{8'h55, 8'h62, 15, 0, 1'b1, 8'd3};
        tv[5] = '{8'hAD, 8'h9A, 0, 5, 1'b1, 8'd3};
        tv[6] = '{8'h3C, 8'h0B, 3, 2, 1'b1, 8'd3};
        tv[7] = '{8'h00, 8'h37, 1, 0, 1'b1, 8'd3};
        tv[8] = '{8'hFF, 8'hC8, 0, 1, 1'b1, 8'd3};
        tv[9] = '{8'h12, 8'h12, 2, 0, 1'b0, 8'd4};

        reset = 1'b1;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        idle_outputs("reset");

        for (int i = 0; i < 10; i++) begin
            run_frame(tv[i].d, tv[i].c, tv[i].gap, tv[i].hold, tv[i].ack);
            cmp("tbl_err", bus.err_count, tv[i].err);
            cmp("tbl_odata", bus.out_data, exp_od);
        end

        // reset while waiting for the checksum
        bus.in_data = 8'h5A;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        tick;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        exp_err = 8'd0;
        exp_od = 8'd0;
        idle_outputs("rst_wait");
        repeat (TIMEOUT + 2) begin
            tick;
            cmp("rst_wait_nack", bus.nack, 1'b0);
            cmp("rst_wait_busy", bus.busy, 1'b0);
        end

        // reset while holding a good payload, against in_valid and out_ready
        bus.in_data = 8'h11;
        bus.in_valid = 1'b1;
        tick;
        bus.in_data = 8'h11 ^ KEY;
        tick;
        bus.in_valid = 1'b0;
        tick;
        cmp("pre_hold_ovalid", bus.out_valid, 1'b1);
        tick;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        idle_outputs("rst_hold");
        tick;
        idle_outputs("rst_hold2");

        for (int i = 0; i < 300; i++) run_frame(8'(i), 8'(i), 0, 0, 1'b0);
        cmp("sat_err", bus.err_count, 8'hFF);
        run_frame(8'h21, 8'h21 ^ KEY, 0, 0, 1'b1);
        cmp("sat_keep", bus.err_count, 8'hFF);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] d, c;
            int gap, hold;
            d = 8'($urandom);
            c = ($urandom_range(0, 1) == 1) ? d ^ KEY : 8'($urandom);
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 15);
            hold = $urandom_range(0, 4);
            run_frame(d, c, gap, hold, gap < TIMEOUT && c == (d ^ KEY));
            repeat ($urandom_range(0, 2)) begin
                tick;
                cmp("rnd_idle_ack", bus.ack, 1'b0);
                cmp("rnd_idle_nack", bus.nack, 1'b0);
            end
            cmp("rnd_err", bus.err_count, exp_err);
            cmp("rnd_odata", bus.out_data, exp_od);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bus_frame_rx.md
BUS_FRAME_RX -- requirements
Module: bus_frame_rx

Interface
REQ-001 KEY, 8'b00110111, checksum key; a frame is valid iff chk == data ^ KEY.
REQ-002 TIMEOUT, 16, maximum cycles spent waiting for the checksum byte; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  incoming bus byte.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 out_data  output  8  payload of the last valid frame.
REQ-009 out_valid  output  1  out_data holds an unconsumed valid payload.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 ack  output  1  one-cycle pulse when a frame passes the check.
REQ-012 nack  output  1  one-cycle pulse when a frame fails the check or times out.
REQ-013 err_count  output  8  count of nacked frames, saturating.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT_CHK, CHECK and HOLD; a byte is accepted at an edge where in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE and WAIT_CHK and 0 in CHECK and HOLD; bytes offered while in_ready=0 are ignored and not counted.
REQ-017 IDLE: on accept, latch in_data as data, clear the timer and go to WAIT_CHK; otherwise stay.
REQ-018 WAIT_CHK: on accept, latch in_data as chk and go to CHECK; otherwise increment the timer.
REQ-019 WAIT_CHK timeout: when the timer == TIMEOUT-1 with no accept, discard the frame, pulse nack, increment err_count and go to IDLE, so WAIT_CHK lasts at most TIMEOUT cycles.
REQ-020 An accept in the same cycle as the timeout condition SHALL take priority; no timeout occurs.
REQ-021 CHECK lasts exactly one cycle and evaluates (data ^ KEY) == chk.
REQ-022 On a match, the next edge SHALL set out_data=data and out_valid=1, pulse ack for one cycle and enter HOLD.
REQ-023 On a mismatch, the next edge SHALL pulse nack for one cycle, increment err_count and enter IDLE; out_data is unchanged.
REQ-024 ack, nack and out_valid SHALL be registered outputs; ack and nack are never high simultaneously.
REQ-025 Latency: a checksum accepted at edge N gives ack/nack and out_valid high during the cycle after edge N+1.
REQ-026 HOLD: out_valid stays 1 and out_data stays stable until an edge with out_ready=1; at that edge out_valid becomes 0 and the state goes to IDLE.
REQ-027 If out_ready is already 1 when out_valid rises, the transfer completes at the next edge; the minimum frame period is 4 cycles.
REQ-028 err_count SHALL saturate at 8'hFF; further nacks still pulse.
REQ-029 busy SHALL be registered-state decoded: busy = (state != IDLE).

Reset
REQ-030 While reset=1 at an edge: state=IDLE and timer, data, chk, out_data and err_count are all 0; out_valid, ack and nack are 0; in_ready=1 and busy=0 from the following cycle.
REQ-031 Reset SHALL dominate in_valid and out_ready in the same cycle.
REQ-032 A reset mid-frame (WAIT_CHK, CHECK or HOLD) SHALL discard the frame with no ack/nack pulse and no err_count change apart from the clear.

Verification
REQ-033 Bytes AA then 9D (AA^37) -> ack pulse, out_valid=1 with out_data=AA, err_count=0; out_ready=1 -> out_valid=0 and state IDLE next cycle.
REQ-034 Bytes AD then 9B (AD^36) and AF then AF (AF^00) -> two nack pulses, no out_valid, err_count=2, out_data unchanged.
REQ-035 Byte 55 then in_valid=0 -> nack exactly 16 cycles after the data accept, err_count+1, in_ready stays 1; checksum offered on the 16th cycle -> accepted with no timeout.
REQ-036 Good frame AD/9A with out_ready=0 for 5 cycles while in_valid=1 -> out_valid and out_data=AD held, in_ready=0, no extra bytes latched; release -> IDLE.
REQ-037 Reset asserted in WAIT_CHK and in HOLD -> all outputs 0 next cycle, no ack/nack; 300 bad frames -> err_count=FF.
